// File: rtl/taxi_apb_arb_pkg.sv
// Shared types for the APB round-robin arbiter.
// Holds the FSM encoding and the grant index width helper.
package taxi_apb_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETUP,
    ST_ACCESS
  } arb_state_t;

  // Grant index width, never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/taxi_apb_if.sv
// APB bus bundle.
// req drives the request side, cmp answers it.
interface taxi_apb_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int STRB_W = DATA_W / 8
);

  logic [ADDR_W-1:0] paddr;
  logic [2:0]        pprot;
  logic              psel;
  logic              penable;
  logic              pwrite;
  logic [DATA_W-1:0] pwdata;
  logic [STRB_W-1:0] pstrb;
  logic              pready;
  logic [DATA_W-1:0] prdata;
  logic              pslverr;

  modport req (
    output paddr, pprot, psel, penable,
    output pwrite, pwdata, pstrb,
    input  pready, prdata, pslverr
  );

  modport cmp (
    input  paddr, pprot, psel, penable,
    input  pwrite, pwdata, pstrb,
    output pready, prdata, pslverr
  );

endinterface

// File: rtl/taxi_apb_arb_rr.sv
// Cyclic priority picker.
// Winner is the first requester strictly after last.
module taxi_apb_arb_rr
  import taxi_apb_arb_pkg::*;
#(
  parameter int PORTS = 2,
  localparam int IW = idx_w(PORTS)
) (
  input  logic [PORTS-1:0] req,
  input  logic [IW-1:0]    last,
  output logic [IW-1:0]    gnt,
  output logic             vld
);

  int j;

  // Scan from farthest to nearest so the nearest hit wins.
  always_comb begin
    gnt = last;
    vld = 1'b0;
    j   = 0;
    for (int i = PORTS; i >= 1; i--) begin
      j = (int'(last) + i) % PORTS;
      if (req[j]) begin
        gnt = IW'(j);
        vld = 1'b1;
      end
    end
  end

endmodule

// File: rtl/taxi_apb_arb.sv
// Round-robin APB arbiter: many requesters, one completer.
// Registers the winning request and replays it downstream.
module taxi_apb_arb
  import taxi_apb_arb_pkg::*;
#(
  parameter int PORTS   = 2,
  parameter int TIMEOUT = 1024,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32
) (
  input logic     clk,
  input logic     rst,
  taxi_apb_if.cmp s_apb [PORTS],
  taxi_apb_if.req m_apb
);

  localparam int IW = idx_w(PORTS);
  localparam int SW = DATA_W / 8;
  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  arb_state_t state, nxt;

  logic [PORTS-1:0]  req;
  logic [IW-1:0]     rr_gnt;
  logic              rr_vld;
  logic [IW-1:0]     last;
  logic [ADDR_W-1:0] addr;
  logic [2:0]        prot;
  logic              write;
  logic [DATA_W-1:0] wdata;
  logic [SW-1:0]     strb;
  logic              rsp;
  logic [DATA_W-1:0] rdata;
  logic              err;
  logic [CW-1:0]     cnt;
  logic              cap;
  logic              done;
  logic              tmo;
  logic              wd_hit;

  logic [ADDR_W-1:0] s_addr  [PORTS];
  logic [2:0]        s_prot  [PORTS];
  logic              s_write [PORTS];
  logic [DATA_W-1:0] s_wdata [PORTS];
  logic [SW-1:0]     s_strb  [PORTS];

  for (genvar i = 0; i < PORTS; i++) begin : g_port
    logic hit;
    assign hit     = rsp && (last == IW'(i));
    assign req[i]     = s_apb[i].psel;
    assign s_addr[i]  = s_apb[i].paddr;
    assign s_prot[i]  = s_apb[i].pprot;
    assign s_write[i] = s_apb[i].pwrite;
    assign s_wdata[i] = s_apb[i].pwdata;
    assign s_strb[i]  = s_apb[i].pstrb;
    assign s_apb[i].pready  = hit;
    assign s_apb[i].prdata  = hit ? rdata : '0;
    assign s_apb[i].pslverr = hit && err;
  end

  taxi_apb_arb_rr #(
    .PORTS(PORTS)
  ) u_rr (
    .req (req),
    .last(last),
    .gnt (rr_gnt),
    .vld (rr_vld)
  );

  assign wd_hit = (TIMEOUT != 0) &&
                  (cnt == CW'(TIMEOUT - 1));

  // Next state; the response cycle never samples requests.
  always_comb begin
    nxt  = state;
    cap  = 1'b0;
    done = 1'b0;
    tmo  = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (rr_vld && !rsp) begin
          nxt = ST_SETUP;
          cap = 1'b1;
        end
      end
      ST_SETUP: nxt = ST_ACCESS;
      ST_ACCESS: begin
        if (m_apb.pready) begin
          nxt  = ST_IDLE;
          done = 1'b1;
        end else if (wd_hit) begin
          nxt = ST_IDLE;
          tmo = 1'b1;
        end
      end
      default: nxt = ST_IDLE;
    endcase
  end

  // State, capture, response and watchdog registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      last  <= IW'(PORTS - 1);
      addr  <= '0;
      prot  <= '0;
      write <= 1'b0;
      wdata <= '0;
      strb  <= '0;
      rsp   <= 1'b0;
      rdata <= '0;
      err   <= 1'b0;
      cnt   <= '0;
    end else begin
      state <= nxt;
      rsp   <= done | tmo;
      if (cap) begin
        last  <= rr_gnt;
        addr  <= s_addr[rr_gnt];
        prot  <= s_prot[rr_gnt];
        write <= s_write[rr_gnt];
        wdata <= s_wdata[rr_gnt];
        strb  <= s_strb[rr_gnt];
      end
      if (done) begin
        rdata <= m_apb.prdata;
        err   <= m_apb.pslverr;
      end else if (tmo) begin
        rdata <= '0;
        err   <= 1'b1;
      end
      if (state != ST_ACCESS) begin
        cnt <= '0;
      end else if (TIMEOUT != 0) begin
        cnt <= cnt + CW'(1);
      end
    end
  end

  assign m_apb.psel    = (state != ST_IDLE);
  assign m_apb.penable = (state == ST_ACCESS);
  assign m_apb.paddr   = addr;
  assign m_apb.pprot   = prot;
  assign m_apb.pwrite  = write;
  assign m_apb.pwdata  = wdata;
  assign m_apb.pstrb   = strb;

endmodule
